// File: rtl/sound_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sound_pkg
// Brief    : Shared sample type, frame geometry and config reset value for
//            the sigma-delta sound capture path.
// Revision : 1.0 - initial release
// ============================================================================
package sound_pkg;

  localparam int          SAMPLE_W    = 8;
  localparam int          FRAME_TICKS = 256;
  localparam logic [15:0] CPC_RESET   = 16'd18;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // A frame of all ones sums to FRAME_TICKS, one past the largest sample code.
  function automatic sample_t sat_sample(input logic [SAMPLE_W:0] sum);
    return (sum > {1'b0, {SAMPLE_W{1'b1}}}) ? {SAMPLE_W{1'b1}} : sum[SAMPLE_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/capture_fifo.sv
`default_nettype none
// ============================================================================
// Module   : capture_fifo
// Brief    : Synchronous first-word-fall-through sample FIFO with a
//            registered head output and an occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module capture_fifo
  import sound_pkg::*;
#(
  parameter int DEPTH   = 512,
  parameter int COUNT_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_push,
  input  sample_t            i_data,
  input  logic               i_pop,
  output sample_t            o_head,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_push_acc,
  output logic               o_pop_acc,
  output logic               o_drop
);

  localparam int PTR_W = $clog2(DEPTH);

  sample_t            r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   w_rd_next;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] w_count_next;
  sample_t            r_head;
  sample_t            w_head_next;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == COUNT_W'(DEPTH));

  // A pop on an empty FIFO is ignored; a push on a full one only lands if a pop frees a slot.
  assign w_pop  = i_pop && !w_empty;
  assign w_push = i_push && (!w_full || w_pop);

  assign w_rd_next    = r_rd_ptr + PTR_W'(w_pop);
  assign w_count_next = r_count + COUNT_W'(w_push) - COUNT_W'(w_pop);

  always_comb begin
    w_head_next = r_head;
    if (w_count_next != '0) begin
      if (w_push && (w_rd_next == r_wr_ptr)) begin
        w_head_next = i_data;
      end else begin
        w_head_next = r_mem[w_rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_head   <= w_head_next;
    end
  end

  assign o_head     = r_head;
  assign o_count    = r_count;
  assign o_push_acc = w_push;
  assign o_pop_acc  = w_pop;
  assign o_drop     = i_push && w_full && !w_pop;

endmodule
`default_nettype wire

// File: rtl/sound_capture_core.sv
`default_nettype none
// ============================================================================
// Module   : sound_capture_core
// Brief    : Sigma-delta audio capture: synchronises the comparator bit,
//            decimates it to 8-bit samples over 256-tick frames and buffers
//            the samples in a FIFO drained by the master.
// Options  : SOUND_CAPTURE_OVERRUN_IRQ_EN - overrun onset also pulses soundIrq.
// Revision : 1.0 - initial release
// ============================================================================
module sound_capture_core
  import sound_pkg::*;
#(
  parameter int DEPTH     = 512,
  parameter int COUNT_W   = 10,
  parameter int IRQ_LEVEL = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bitIn,
  input  logic [15:0]        clocksPerCycleIn,
  input  logic               soundIreIn,
  input  logic               captureEnIn,
  input  logic               configLoadEn,
  input  logic               overrunClr,
  input  logic               bufferReadEn,
  output logic [7:0]         bufferDataOut,
  output logic [COUNT_W-1:0] wordCount,
  output logic [15:0]        clocksPerCycle,
  output logic               soundIre,
  output logic               captureEn,
  output logic               overrun,
  output logic               soundIrq,
  output logic               feedbackOut
);

  localparam int TICK_W = $clog2(FRAME_TICKS);

  logic                r_sync1;
  logic                r_syncBit;
  logic [15:0]         r_cpc;
  logic                r_ire;
  logic                r_capEn;
  logic [15:0]         r_presc;
  logic [TICK_W-1:0]   r_tickCount;
  logic [SAMPLE_W:0]   r_onesCount;
  logic                r_feedback;
  logic                r_push;
  sample_t             r_sample;
  logic                r_overrun;
  logic                r_irq;

  logic [15:0]         w_last;
  logic                w_tick;
  logic                w_frame_end;
  logic [SAMPLE_W:0]   w_sum;
  sample_t             w_head;
  logic [COUNT_W-1:0]  w_count;
  logic                w_push_acc;
  logic                w_pop_acc;
  logic                w_drop;
  logic                w_cross;
  logic                w_irq_event;

  // A programmed period of zero behaves as a period of one.
  assign w_last      = (r_cpc == 16'd0) ? 16'd0 : r_cpc - 16'd1;
  assign w_tick      = r_capEn && (r_presc >= w_last);
  assign w_frame_end = w_tick && (r_tickCount == TICK_W'(FRAME_TICKS - 1));
  assign w_sum       = r_onesCount + {{SAMPLE_W{1'b0}}, r_syncBit};

  assign w_cross = w_push_acc && !w_pop_acc && (w_count == COUNT_W'(IRQ_LEVEL - 1));

`ifdef SOUND_CAPTURE_OVERRUN_IRQ_EN
  assign w_irq_event = w_cross || (w_drop && !r_overrun);
`else
  assign w_irq_event = w_cross;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1     <= 1'b0;
      r_syncBit   <= 1'b0;
      r_cpc       <= CPC_RESET;
      r_ire       <= 1'b0;
      r_capEn     <= 1'b0;
      r_presc     <= '0;
      r_tickCount <= '0;
      r_onesCount <= '0;
      r_feedback  <= 1'b0;
      r_push      <= 1'b0;
      r_sample    <= '0;
      r_overrun   <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_sync1   <= bitIn;
      r_syncBit <= r_sync1;

      // A config write always restarts the decimator, dropping any partial frame.
      if (configLoadEn) begin
        r_cpc       <= clocksPerCycleIn;
        r_ire       <= soundIreIn;
        r_capEn     <= captureEnIn;
        r_presc     <= '0;
        r_tickCount <= '0;
        r_onesCount <= '0;
      end else if (!r_capEn) begin
        r_presc    <= '0;
        r_feedback <= 1'b0;
      end else if (w_tick) begin
        r_presc    <= '0;
        r_feedback <= r_syncBit;
        if (w_frame_end) begin
          r_sample    <= sat_sample(w_sum);
          r_onesCount <= '0;
          r_tickCount <= '0;
        end else begin
          r_onesCount <= w_sum;
          r_tickCount <= r_tickCount + TICK_W'(1);
        end
      end else begin
        r_presc <= r_presc + 16'd1;
      end

      r_push <= w_frame_end && !configLoadEn;

      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (overrunClr) begin
        r_overrun <= 1'b0;
      end

      r_irq <= r_ire && w_irq_event;
    end
  end

  capture_fifo #(
    .DEPTH   (DEPTH),
    .COUNT_W (COUNT_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (r_push),
    .i_data     (r_sample),
    .i_pop      (bufferReadEn),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_push_acc (w_push_acc),
    .o_pop_acc  (w_pop_acc),
    .o_drop     (w_drop)
  );

  assign bufferDataOut  = w_head;
  assign wordCount      = w_count;
  assign clocksPerCycle = r_cpc;
  assign soundIre       = r_ire;
  assign captureEn      = r_capEn;
  assign overrun        = r_overrun;
  assign soundIrq       = r_irq;
  assign feedbackOut    = r_feedback;

endmodule
`default_nettype wire

// File: doc/sound_capture_core.md
Name: sound_capture_core

Overview:
- Audio input path; the receive-side counterpart of the sigma-delta playback core.
- Takes a 1-bit sigma-delta bitstream from an external comparator and its RC network.
- Drives the registered comparator bit back out as the modulator feedback.
- Decimates the bitstream into 8-bit samples by counting ones over 256 ticks, then buffers samples in a FIFO for the master interface, which drains it; raises an interrupt when the FIFO reaches a fill level.

Parameters:
- DEPTH, 512: FIFO entries; power of two.
- COUNT_W, 10: wordCount width; equals log2(DEPTH)+1.
- IRQ_LEVEL, 256: wordCount value whose upward crossing raises soundIrq.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- bitIn  in  1  asynchronous comparator output.
- clocksPerCycleIn  in  16  config data from master.
- soundIreIn  in  1  config data from master: interrupt enable.
- captureEnIn  in  1  config data from master: capture enable.
- configLoadEn  in  1  config write strobe.
- overrunClr  in  1  clears the sticky overrun flag.
- bufferReadEn  in  1  pop strobe from master.
- bufferDataOut  out  8  FIFO head sample (first-word-fall-through).
- wordCount  out  COUNT_W  FIFO occupancy.
- clocksPerCycle  out  16  visible config.
- soundIre  out  1  visible config.
- captureEn  out  1  visible config.
- overrun  out  1  sticky: a sample was dropped.
- soundIrq  out  1  one-cycle interrupt pulse.
- feedbackOut  out  1  modulator feedback bit.

Behaviour:
- Reset values: clocksPerCycle=18; soundIre=0; captureEn=0; overrun=0; soundIrq=0; feedbackOut=0; wordCount=0; bufferDataOut=0; all decimator state=0.
- Config: on configLoadEn, load clocksPerCycle, soundIre and captureEn from their inputs. The same write also restarts the decimator: prescaler, tickCount and onesCount go to 0, so a partial frame is discarded.
- Synchronizer: bitIn passes through two flops (syncBit) before any use.
- Prescaler:
  - Counts 0..N-1, where N=max(clocksPerCycle,1).
  - A tick fires in the cycle where prescaler==N-1; the prescaler then wraps to 0.
  - Held at 0 while captureEn=0.
- On each tick:
  - feedbackOut <= syncBit.
  - onesCount (9 bits) += syncBit.
  - tickCount (8 bits) increments.
- Frame end, on the tick with tickCount==255:
  - sample = min(onesCount + syncBit, 255).
  - Push the sample into the FIFO in the next cycle.
  - onesCount <= 0; tickCount wraps to 0.
- captureEn=0: no ticks and no pushes; feedbackOut held at 0. FIFO contents and reads are unaffected.
- FIFO, first-word-fall-through:
  - bufferDataOut shows the head entry whenever wordCount!=0 and is registered.
  - A pushed word into an empty FIFO is visible on bufferDataOut one cycle after the push.
  - bufferReadEn pops the head; when wordCount==0 it is ignored and nothing changes.
  - Push while full: the sample is dropped, overrun <= 1, wordCount stays DEPTH.
  - Push and pop together when full: both take effect, wordCount unchanged, no overrun.
  - Push and pop together when empty: only the push takes effect.
  - Pointers wrap modulo DEPTH.
- Overrun: sticky; cleared only by overrunClr or reset. A set and a clear in the same cycle leaves it set.
- soundIrq: registered one-cycle pulse, asserted the cycle after wordCount goes from IRQ_LEVEL-1 to IRQ_LEVEL through a push, and only if soundIre=1. Reaching IRQ_LEVEL by popping never raises it.
- Reset mid-frame or mid-FIFO: every register returns to its reset value and any partial frame is lost.

Optional Feature:
- Macro: SOUND_CAPTURE_OVERRUN_IRQ_EN.
- Defined: soundIrq also pulses for one cycle on the cycle after overrun goes from 0 to 1, if soundIre=1.
- Undefined: overrun is status-only and never affects soundIrq.

Decomposition:
- Package sound_pkg holds:
  - SAMPLE_W=8.
  - FRAME_TICKS=256.
  - CPC_RESET=16'd18.
  - typedef sample_t (logic [7:0]).
- Sub-module capture_fifo holds the synchronous FWFT FIFO: write/read pointers, wordCount, and full/empty logic.
- The decimator, config registers and IRQ logic stay in sound_capture_core.

Test Plan:
- Reset value: after reset, clocksPerCycle reads 18, wordCount=0, soundIrq=0, feedbackOut=0.
- All ones: clocksPerCycle=1, captureEn=1, bitIn=1 → first sample 0xFF, wordCount=1 within 256+4 cycles, feedbackOut=1.
- All zeros and 50%: bitIn=0 gives sample 0x00; bitIn toggling every tick gives sample 0x80.
- Prescaler: clocksPerCycle=4, bitIn=1 → one push every 1024 cycles. clocksPerCycle=0 behaves exactly like 1.
- IRQ and overflow:
  - soundIre=1, no reads → exactly one soundIrq pulse as wordCount reaches 256.
  - Fill to 512, then one more frame → overrun=1 and wordCount stays 512.
  - One bufferReadEn coinciding with a push at full → wordCount=512 and no overrun.
- Mid-frame restart: assert configLoadEn or reset at tick 100 of a frame → no sample from the partial frame; the next sample needs a full 256 ticks.
